// File: rtl/x_pkg.sv
// Shared types and constants for the operand loader and its watchdog counter.
// Holds the sequencer state encoding, register-file slot indices and default sizes.
package x_pkg;

    localparam int X_WIDTH = 16;
    localparam int X_NREG  = 5;

    localparam int SLOT_A      = 0;
    localparam int SLOT_B      = 1;
    localparam int SLOT_ACC_LO = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_B,
        START,
        BUSY,
        OUT
    } state_e;

endpackage

// File: rtl/x_wdog_cnt.sv
// Purpose: saturating timeout counter, counts cycles while en_i is high.
// Latency: expired_o is combinational from the count; it is high on the TIMEOUT-th enabled cycle.
// Backpressure: none; the count clears whenever en_i drops.
module x_wdog_cnt #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || !en_i) begin
            cnt_q <= '0;
        end else if (cnt_q != LAST) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/x_operand_loader.sv
// Purpose: loads A/B into slots 0/1, starts the multiplier, holds the product until consumed.
// Latency: out_valid rises the cycle after done; B transfer to out_valid is 2 cycles plus compute time.
// Backpressure: in_ready low outside IDLE/LOAD_B; OUT holds until out_ready. Watchdog: X_LOADER_WATCHDOG_EN.
module x_operand_loader
    import x_pkg::*;
#(
    parameter int WIDTH   = X_WIDTH,
    parameter int NREG    = X_NREG,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic [NREG-1:0]    ld_en,
    output logic [WIDTH-1:0]   ld_data,
    output logic               clr_acc,
    output logic               start,
    input  logic               done,
    input  logic [2*WIDTH-1:0] res_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_data,
    output logic               busy,
    output logic [7:0]         op_count,
    output logic               err
);

    state_e             state_q, state_d;
    logic [2*WIDTH-1:0] out_data_q, out_data_d;
    logic [7:0]         op_count_q, op_count_d;
    logic               xfer;

`ifdef X_LOADER_WATCHDOG_EN
    logic err_q, err_d;
    logic wdog_expired;

    x_wdog_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .en_i      (state_q == BUSY),
        .expired_o (wdog_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Reset gates the handshake so nothing is accepted in a reset cycle.
    assign xfer = in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        op_count_d = op_count_q;
        in_ready   = 1'b0;
        ld_en      = '0;
        start      = 1'b0;
        clr_acc    = 1'b0;
`ifdef X_LOADER_WATCHDOG_EN
        err_d      = err_q;
`endif
        case (state_q)
            IDLE: begin
                in_ready = !rst;
                if (in_valid && !rst) begin
                    ld_en   = NREG'(1) << SLOT_A;
                    state_d = LOAD_B;
`ifdef X_LOADER_WATCHDOG_EN
                    err_d   = 1'b0;
`endif
                end
            end
            LOAD_B: begin
                in_ready = !rst;
                if (in_valid && !rst) begin
                    ld_en   = NREG'(1) << SLOT_B;
                    state_d = START;
                end
            end
            START: begin
                start   = 1'b1;
                clr_acc = 1'b1;
                state_d = BUSY;
            end
            BUSY: begin
                // A done in the timeout cycle takes priority and leaves err alone.
                if (done) begin
                    out_data_d = res_data;
                    state_d    = OUT;
                end
`ifdef X_LOADER_WATCHDOG_EN
                else if (wdog_expired) begin
                    out_data_d = '0;
                    err_d      = 1'b1;
                    state_d    = OUT;
                end
`endif
            end
            OUT: begin
                if (out_ready) begin
                    op_count_d = op_count_q + 8'd1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            out_data_q <= '0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            op_count_q <= op_count_d;
        end
    end

    assign ld_data   = in_data;
    assign out_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE);
    assign out_data  = out_data_q;
    assign op_count  = op_count_q;

    logic unused_xfer;
    assign unused_xfer = xfer;

endmodule
